// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_t          : arbiter FSM states
//   WIDTH_WORD       : width code for a 32-bit access
//   READ_LAT_DEF     : default memory read latency (cycles)
//   DMA_MAX_WAIT_DEF : default number of lost arbitrations tolerated by the DMA
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_RD   = 2'd1,
    DMA_RD   = 2'd2,
    CPU_DONE = 2'd3
  } state_t;

  localparam logic [1:0] WIDTH_WORD = 2'b10;

  localparam int READ_LAT_DEF     = 1;
  localparam int DMA_MAX_WAIT_DEF = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the CPU MEM stage, the DMA engine, the data memory
// and the arbiter.
//   cpu_*  : CPU request (req/wr/width/unsigned/addr/wdata), stall and load data
//   dma_*  : DMA request (req/wr/addr/wdata), grant pulse, read data and valid
//   mem_*  : strobes, width, zero-extend, address and write data to memory,
//            read data back from memory
// Modports:
//   slave  : the arbiter
//   master : the surrounding requesters and memory
interface dmem_arbiter_if;

  logic        cpu_req;
  logic        cpu_wr;
  logic [1:0]  cpu_width;
  logic        cpu_unsigned;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic        dma_wr;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;

  logic        mem_rd_en;
  logic        mem_wrt_en;
  logic [1:0]  mem_width;
  logic        mem_unsigned;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rd_data;

  modport slave (
    input  cpu_req, cpu_wr, cpu_width, cpu_unsigned, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata,
    input  dma_req, dma_wr, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_rd_en, mem_wrt_en, mem_width, mem_unsigned, mem_addr, mem_wdata,
    input  mem_rd_data
  );

  modport master (
    output cpu_req, cpu_wr, cpu_width, cpu_unsigned, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata,
    output dma_req, dma_wr, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_rd_en, mem_wrt_en, mem_width, mem_unsigned, mem_addr, mem_wdata,
    output mem_rd_data
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a DMA engine.
// Arbitration happens only when idle. The CPU normally wins, but once the DMA
// has lost DMA_MAX_WAIT consecutive arbitrations it is forced to win. Writes
// complete in their issue cycle; reads wait READ_LAT cycles for memory data.
// Ports:
//   clk : sole clock, all state on posedge
//   rst : synchronous active-high reset
//   bus : dmem_arbiter_if.slave (CPU, DMA and memory signals)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int READ_LAT     = READ_LAT_DEF,
  parameter int DMA_MAX_WAIT = DMA_MAX_WAIT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int SW = (DMA_MAX_WAIT < 1) ? 1 : $clog2(DMA_MAX_WAIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(DMA_MAX_WAIT);
  localparam logic [1:0]    LAT_END    = 2'(READ_LAT);

  state_t        state, state_nx;
  logic [1:0]    lat_cnt, lat_cnt_nx;
  logic [SW-1:0] starve_cnt, starve_nx;
  logic          cpu_win, dma_win, capture;

  always_comb begin
    state_nx         = state;
    lat_cnt_nx       = lat_cnt;
    starve_nx        = starve_cnt;
    cpu_win          = 1'b0;
    dma_win          = 1'b0;
    capture          = 1'b0;
    bus.mem_rd_en    = 1'b0;
    bus.mem_wrt_en   = 1'b0;
    bus.mem_width    = bus.cpu_width;
    bus.mem_unsigned = bus.cpu_unsigned;
    bus.mem_addr     = bus.cpu_addr;
    bus.mem_wdata    = bus.cpu_wdata;
    bus.dma_gnt      = 1'b0;
    bus.cpu_stall    = 1'b0;

    case (state)
      IDLE: begin
        // lat_cnt sits at 0 while idle; the issue edge advances it to 1 so
        // it equals READ_LAT in the cycle the memory data is valid.
        lat_cnt_nx = 2'd0;
        if (bus.cpu_req && (!bus.dma_req || (starve_cnt < STARVE_MAX))) begin
          cpu_win = 1'b1;
        end else if (bus.dma_req) begin
          dma_win = 1'b1;
        end

        if (cpu_win) begin
          bus.mem_rd_en  = !bus.cpu_wr;
          bus.mem_wrt_en = bus.cpu_wr;
          if (!bus.cpu_wr) begin
            state_nx   = CPU_RD;
            lat_cnt_nx = 2'd1;
          end
        end else if (dma_win) begin
          bus.dma_gnt      = 1'b1;
          bus.mem_rd_en    = !bus.dma_wr;
          bus.mem_wrt_en   = bus.dma_wr;
          bus.mem_width    = WIDTH_WORD;
          bus.mem_unsigned = 1'b0;
          bus.mem_addr     = bus.dma_addr;
          bus.mem_wdata    = bus.dma_wdata;
          if (!bus.dma_wr) begin
            state_nx   = DMA_RD;
            lat_cnt_nx = 2'd1;
          end
        end

        if (!bus.dma_req || dma_win) begin
          starve_nx = '0;
        end else if (cpu_win && (starve_cnt < STARVE_MAX)) begin
          starve_nx = starve_cnt + 1'b1;
        end
      end

      CPU_RD, DMA_RD: begin
        if (lat_cnt == LAT_END) begin
          capture    = 1'b1;
          lat_cnt_nx = 2'd0;
          state_nx   = (state == CPU_RD) ? CPU_DONE : IDLE;
        end else begin
          lat_cnt_nx = lat_cnt + 2'd1;
        end
        if (!bus.dma_req) starve_nx = '0;
      end

      CPU_DONE: begin
        state_nx = IDLE;
        if (!bus.dma_req) starve_nx = '0;
      end

      default: state_nx = IDLE;
    endcase

    // The CPU only proceeds on a store issuing now or once its load data is in.
    bus.cpu_stall = bus.cpu_req && !((cpu_win && bus.cpu_wr) || (state == CPU_DONE));

    if (rst) begin
      bus.mem_rd_en  = 1'b0;
      bus.mem_wrt_en = 1'b0;
      bus.dma_gnt    = 1'b0;
      bus.cpu_stall  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      lat_cnt        <= 2'd0;
      starve_cnt     <= '0;
      bus.cpu_rdata  <= 32'd0;
      bus.dma_rdata  <= 32'd0;
      bus.dma_rvalid <= 1'b0;
    end else begin
      state          <= state_nx;
      lat_cnt        <= lat_cnt_nx;
      starve_cnt     <= starve_nx;
      bus.dma_rvalid <= capture && (state == DMA_RD);
      if (capture && (state == CPU_RD)) bus.cpu_rdata <= bus.mem_rd_data;
      if (capture && (state == DMA_RD)) bus.dma_rdata <= bus.mem_rd_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level model that tracks when the memory is
// free, when each pending read completes, and a shadow copy of memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int LAT  = 1;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.READ_LAT(LAT), .DMA_MAX_WAIT(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents before any write: fixed words at the two directed
  // addresses, a scrambled address pattern elsewhere.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    if (a == 32'h200) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- memory environment (1-cycle read latency) -------------
  bit   [31:0] tbmem [256];
  bit          tbwr  [256];
  logic [31:0] rd_q, junk;
  logic        rd_vld = 1'b0;

  always @(posedge clk) begin
    junk   <= $urandom;
    rd_vld <= bus.mem_rd_en;
    rd_q   <= tbwr[bus.mem_addr[9:2]] ? tbmem[bus.mem_addr[9:2]]
                                      : dflt({22'd0, bus.mem_addr[9:2], 2'b00});
    if (bus.mem_wrt_en) begin
      tbmem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      tbwr[bus.mem_addr[9:2]]  <= 1'b1;
    end
  end
  // Outside the valid cycle memory presents random garbage.
  assign bus.mem_rd_data = rd_vld ? rd_q : junk;

  // ---------------- reference model ----------------------------------------
  bit   [31:0] shadow [256];
  bit          shw    [256];
  int          cyc, free_cyc, cpu_cap_cyc, dma_cap_cyc, cpu_done_cyc, starve, n_starve;
  logic [31:0] cpu_pend, dma_pend, exp_cpu_rdata, exp_dma_rdata;
  logic        exp_rvalid;
  bit          e_cpu_win, e_dma_win;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return shw[a[9:2]] ? shadow[a[9:2]] : dflt({22'd0, a[9:2], 2'b00});
  endfunction

  task automatic set_cpu(input bit req, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_req      = req;
    bus.cpu_wr       = wr;
    bus.cpu_addr     = a;
    bus.cpu_wdata    = d;
    bus.cpu_width    = 2'($urandom_range(0, 3));
    bus.cpu_unsigned = 1'($urandom_range(0, 1));
  endtask

  task automatic set_dma(input bit req, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bus.dma_req   = req;
    bus.dma_wr    = wr;
    bus.dma_addr  = a;
    bus.dma_wdata = d;
  endtask

  // Compare every output of the current cycle against the model.
  task automatic eval();
    bit idle, done;
    #1;
    idle      = (cyc >= free_cyc);
    done      = (cyc == cpu_done_cyc);
    e_cpu_win = 1'b0;
    e_dma_win = 1'b0;
    if (!rst && idle) begin
      if (bus.cpu_req && (!bus.dma_req || starve < MAXW)) e_cpu_win = 1'b1;
      else if (bus.dma_req) e_dma_win = 1'b1;
    end
    n_starve = starve;
    if (!bus.dma_req || e_dma_win) n_starve = 0;
    else if (e_cpu_win && starve < MAXW) n_starve = starve + 1;

    chk("cpu_stall", bus.cpu_stall,
        32'(!rst && bus.cpu_req && !((e_cpu_win && bus.cpu_wr) || done)));
    chk("dma_gnt", bus.dma_gnt, 32'(e_dma_win));
    chk("mem_rd_en", bus.mem_rd_en,
        32'((e_cpu_win && !bus.cpu_wr) || (e_dma_win && !bus.dma_wr)));
    chk("mem_wrt_en", bus.mem_wrt_en,
        32'((e_cpu_win && bus.cpu_wr) || (e_dma_win && bus.dma_wr)));
    if (e_cpu_win) begin
      chk("cpu_mem_addr", bus.mem_addr, bus.cpu_addr);
      chk("cpu_mem_width", bus.mem_width, bus.cpu_width);
      chk("cpu_mem_unsigned", bus.mem_unsigned, bus.cpu_unsigned);
      if (bus.cpu_wr) chk("cpu_mem_wdata", bus.mem_wdata, bus.cpu_wdata);
    end
    if (e_dma_win) begin
      chk("dma_mem_addr", bus.mem_addr, bus.dma_addr);
      chk("dma_mem_width", bus.mem_width, WIDTH_WORD);
      chk("dma_mem_unsigned", bus.mem_unsigned, 0);
      if (bus.dma_wr) chk("dma_mem_wdata", bus.mem_wdata, bus.dma_wdata);
    end
    chk("cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
    chk("dma_rvalid", bus.dma_rvalid, 32'(exp_rvalid));
    if (exp_rvalid) chk("dma_rdata", bus.dma_rdata, exp_dma_rdata);
  endtask

  // Advance one clock and update the model with this cycle's transactions.
  task automatic adv();
    @(posedge clk);
    if (rst) begin
      free_cyc      = cyc + 1;
      cpu_cap_cyc   = -1;
      dma_cap_cyc   = -1;
      cpu_done_cyc  = -1;
      starve        = 0;
      exp_cpu_rdata = 32'd0;
      exp_dma_rdata = 32'd0;
      exp_rvalid    = 1'b0;
    end else begin
      exp_rvalid = 1'b0;
      if (cyc == cpu_cap_cyc) exp_cpu_rdata = cpu_pend;
      if (cyc == dma_cap_cyc) begin
        exp_dma_rdata = dma_pend;
        exp_rvalid    = 1'b1;
      end
      if (e_cpu_win) begin
        if (bus.cpu_wr) begin
          shadow[bus.cpu_addr[9:2]] = bus.cpu_wdata;
          shw[bus.cpu_addr[9:2]]    = 1'b1;
        end else begin
          cpu_pend     = model_rd(bus.cpu_addr);
          cpu_cap_cyc  = cyc + LAT;
          cpu_done_cyc = cyc + LAT + 1;
          free_cyc     = cyc + LAT + 2;
        end
      end
      if (e_dma_win) begin
        if (bus.dma_wr) begin
          shadow[bus.dma_addr[9:2]] = bus.dma_wdata;
          shw[bus.dma_addr[9:2]]    = 1'b1;
        end else begin
          dma_pend    = model_rd(bus.dma_addr);
          dma_cap_cyc = cyc + LAT;
          free_cyc    = cyc + LAT + 1;
        end
      end
      starve = n_starve;
    end
    cyc++;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_cpu(0, 0, 32'h0, 32'h0);
    set_dma(0, 0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    cyc = 0; free_cyc = 0; cpu_cap_cyc = -1; dma_cap_cyc = -1; cpu_done_cyc = -1;
    starve = 0; exp_cpu_rdata = 0; exp_dma_rdata = 0; exp_rvalid = 0;

    // Reset held with both requesters active: outputs forced low.
    set_cpu(1, 0, 32'h100, 32'h0);
    set_dma(1, 0, 32'h200, 32'h0);
    eval();
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_dma_rdata", bus.dma_rdata, 32'h0);
    chk("rst_dma_rvalid", bus.dma_rvalid, 0);
    chk("rst_stall", bus.cpu_stall, 0);
    chk("rst_gnt", bus.dma_gnt, 0);
    adv();
    rst = 1'b0;
    set_dma(0, 0, 32'h0, 32'h0);

    // CPU load of 0x100: stalled two cycles, then data present.
    set_cpu(1, 0, 32'h100, 32'h0);
    eval(); chk("ld_c0_stall", bus.cpu_stall, 1); chk("ld_c0_rd_en", bus.mem_rd_en, 1); adv();
    eval(); chk("ld_c1_stall", bus.cpu_stall, 1); adv();
    eval(); chk("ld_c2_stall", bus.cpu_stall, 0); chk("ld_c2_rdata", bus.cpu_rdata, 32'hDEADBEEF); adv();
    set_cpu(0, 0, 32'h0, 32'h0);
    eval(); adv();

    // Simultaneous writes: CPU first without stall, DMA granted next cycle.
    set_cpu(1, 1, 32'h120, 32'hA1A1_A1A1);
    set_dma(1, 1, 32'h124, 32'hB2B2_B2B2);
    eval(); chk("ww_c0_stall", bus.cpu_stall, 0); chk("ww_c0_gnt", bus.dma_gnt, 0); adv();
    set_cpu(0, 0, 32'h0, 32'h0);
    eval(); chk("ww_c1_gnt", bus.dma_gnt, 1); chk("ww_c1_addr", bus.mem_addr, 32'h124); adv();
    set_dma(0, 0, 32'h0, 32'h0);

    // Back-to-back CPU stores starve the DMA until its fifth attempt.
    set_dma(1, 1, 32'h140, 32'hC3C3_C3C3);
    for (int i = 0; i < 5; i++) begin
      set_cpu(1, 1, 32'h130 + 32'(4 * i), $urandom);
      eval(); chk("starve_gnt", bus.dma_gnt, 32'(i == 4)); adv();
    end
    set_cpu(1, 1, 32'h150, $urandom);
    set_dma(1, 1, 32'h144, 32'hD4D4_D4D4);
    eval(); chk("starve_clr_gnt", bus.dma_gnt, 0); adv();
    set_cpu(0, 0, 32'h0, 32'h0);
    eval(); chk("starve_clr_gnt2", bus.dma_gnt, 1); adv();
    set_dma(0, 0, 32'h0, 32'h0);

    // DMA read of 0x200: grant now, data valid two cycles later.
    set_dma(1, 0, 32'h200, 32'h0);
    eval(); chk("dr_c0_gnt", bus.dma_gnt, 1); adv();
    set_dma(0, 0, 32'h0, 32'h0);
    eval(); chk("dr_c1_rvalid", bus.dma_rvalid, 0); adv();
    eval(); chk("dr_c2_rvalid", bus.dma_rvalid, 1); chk("dr_c2_rdata", bus.dma_rdata, 32'h1234_5678); adv();

    // Reset while a CPU load is waiting: load abandoned.
    set_cpu(1, 0, 32'h104, 32'h0);
    eval(); adv();
    rst = 1'b1;
    eval(); chk("rrd_stall", bus.cpu_stall, 0); adv();
    rst = 1'b0;
    set_cpu(0, 0, 32'h0, 32'h0);
    eval(); chk("rrd_rdata", bus.cpu_rdata, 32'h0); chk("rrd_stall2", bus.cpu_stall, 0); adv();
    eval(); chk("rrd_rdata2", bus.cpu_rdata, 32'h0); adv();

    // CPU load arriving during a DMA read waits for the idle cycle.
    set_dma(1, 0, 32'h208, 32'h0);
    eval(); adv();
    set_dma(0, 0, 32'h0, 32'h0);
    set_cpu(1, 0, 32'h100, 32'h0);
    eval(); chk("cw_c1_stall", bus.cpu_stall, 1); chk("cw_c1_rd_en", bus.mem_rd_en, 0); adv();
    eval(); chk("cw_c2_rd_en", bus.mem_rd_en, 1); chk("cw_c2_addr", bus.mem_addr, 32'h100); adv();
    eval(); adv();
    eval(); chk("cw_c4_stall", bus.cpu_stall, 0); chk("cw_c4_rdata", bus.cpu_rdata, 32'hDEADBEEF); adv();
    set_cpu(0, 0, 32'h0, 32'h0);

    // Random traffic; the DMA holds its request until granted.
    for (int i = 0; i < 400; i++) begin
      if (!(bus.dma_req && !e_dma_win))
        set_dma($urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)),
                32'h300 + 32'(4 * $urandom_range(0, 15)), $urandom);
      set_cpu($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
              32'h300 + 32'(4 * $urandom_range(0, 15)), $urandom);
      rst = ($urandom_range(0, 99) == 0);
      eval();
      adv();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
